// File: rtl/digit_render_if.sv
// Pixel/digit bus between the VGA timing side and the digit renderer.
// The master drives beam position, frame timing, digit data and colour;
// the slave returns the handshake ready and the rendered pixel colour.
interface digit_render_if #(
   parameter int NUM_DIGITS = 4
);
   logic [9:0]              pixel_x;
   logic [9:0]              pixel_y;
   logic                    video_on;
   logic                    frame_start;
   logic [4*NUM_DIGITS-1:0] digits_in;
   logic                    digits_valid;
   logic                    digits_ready;
   logic [11:0]             fg_rgb;
   logic [11:0]             rgb_out;

   modport master (
      output pixel_x, pixel_y, video_on, frame_start,
      output digits_in, digits_valid, fg_rgb,
      input  digits_ready, rgb_out
   );

   modport slave (
      input  pixel_x, pixel_y, video_on, frame_start,
      input  digits_in, digits_valid, fg_rgb,
      output digits_ready, rgb_out
   );
endinterface

// File: rtl/digit_render_sched.sv
// Digit renderer for an MM:SS timer overlay.
// One shared 7-segment drawing datapath serves NUM_DIGITS slots laid out
// left to right. Incoming digit values are double-buffered so the visible
// digits only change at frame start. Two pipeline stages: slot selection,
// then segment hit test and colour output.
module digit_render_sched #(
   parameter int NUM_DIGITS = 4,
   parameter int DIG_W      = 80,
   parameter int DIG_H      = 160,
   parameter int BAR        = 10,
   parameter int GAP        = 16,
   parameter int ORIGIN_X   = 144,
   parameter int ORIGIN_Y   = 160
) (
   input logic           clk,
   input logic           reset,
   digit_render_if.slave bus
);

   localparam int DW = 4 * NUM_DIGITS;

   // Geometry in 11-bit unsigned so slot right edges never wrap.
   localparam logic [10:0] TOP_Y     = 11'(ORIGIN_Y);
   localparam logic [10:0] BOT_Y     = 11'(ORIGIN_Y + DIG_H);
   localparam logic [10:0] GLYPH_W   = 11'(DIG_W);
   localparam logic [10:0] BAR_W     = 11'(BAR);
   localparam logic [10:0] MID_LO    = 11'((DIG_H - BAR) / 2);
   localparam logic [10:0] MID_HI    = 11'((DIG_H + BAR) / 2);
   localparam logic [10:0] BOT_BAR   = 11'(DIG_H - BAR);
   localparam logic [10:0] RIGHT_BAR = 11'(DIG_W - BAR);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_t;

   // Left edge of slot k.
   function automatic logic [10:0] slot_left(input int k);
      return 11'(ORIGIN_X + k * (DIG_W + GAP));
   endfunction

   // Lit segments for a BCD digit, packed {a,b,c,d,e,f,g}; 10..15 are blank.
   function automatic logic [6:0] seg_mask(input logic [3:0] digit);
      case (digit)
         4'd0:    return 7'b1111110;
         4'd1:    return 7'b0110000;
         4'd2:    return 7'b1101101;
         4'd3:    return 7'b1111001;
         4'd4:    return 7'b0110011;
         4'd5:    return 7'b1011011;
         4'd6:    return 7'b1011111;
         4'd7:    return 7'b1110000;
         4'd8:    return 7'b1111111;
         4'd9:    return 7'b1111011;
         default: return 7'b0000000;
      endcase
   endfunction

   // ------------------------------------------------------------------
   // Digit double buffer
   // ------------------------------------------------------------------
   buf_state_t    state_q, state_d;
   logic [DW-1:0] shadow_q;
   logic [DW-1:0] active_q;
   logic          load_shadow;
   logic          load_direct;
   logic          promote;

   // Buffer FSM: accept one update while empty, publish it at frame start.
   // NOTE: every signal written here gets a default first, so no path through
   // the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d          = state_q;
      load_shadow      = 1'b0;
      load_direct      = 1'b0;
      promote          = 1'b0;
      bus.digits_ready = 1'b0;
      case (state_q)
         EMPTY: begin
            bus.digits_ready = ~reset;
            if (bus.digits_valid && !reset) begin
               if (bus.frame_start) begin
                  load_direct = 1'b1;
               end else begin
                  load_shadow = 1'b1;
                  state_d     = FULL;
               end
            end
         end
         FULL: begin
            if (bus.frame_start) begin
               promote = 1'b1;
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Buffer state and the digits currently on screen.
   // NOTE: state is updated with non-blocking assignments so every register
   // samples the values from before this edge, regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= EMPTY;
         active_q <= '1;
      end else begin
         state_q <= state_d;
         if (load_direct) begin
            active_q <= bus.digits_in;
         end else if (promote) begin
            active_q <= shadow_q;
         end
      end
   end

   // Shadow copy of the pending update.
   // NOTE: the shadow is deliberately left out of reset; it is only read while
   // FULL, and reset forces EMPTY, so a stale value is never published.
   always_ff @(posedge clk) begin
      if (load_shadow) begin
         shadow_q <= bus.digits_in;
      end
   end

   // ------------------------------------------------------------------
   // Stage 1: which slot is under the beam
   // ------------------------------------------------------------------
   logic [10:0] px;
   logic [10:0] py;
   logic        hit_c;
   logic [10:0] lx_c;
   logic [10:0] ly_c;
   logic [3:0]  digit_c;

   logic        hit_d1;
   logic        video_d1;
   logic [10:0] lx_d1;
   logic [10:0] ly_d1;
   logic [3:0]  digit_d1;

   // Exclusive slot decode: slots never overlap, so at most one matches.
   always_comb begin
      px      = {1'b0, bus.pixel_x};
      py      = {1'b0, bus.pixel_y};
      hit_c   = 1'b0;
      lx_c    = '0;
      ly_c    = py - TOP_Y;
      digit_c = 4'hF;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (px >= slot_left(k) && px < slot_left(k) + GLYPH_W &&
             py >= TOP_Y && py < BOT_Y) begin
            hit_c   = 1'b1;
            lx_c    = px - slot_left(k);
            digit_c = active_q[4*k +: 4];
         end
      end
   end

   // Stage 1 qualifiers; cleared by reset so no stale pixel is drawn.
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_d1   <= 1'b0;
         video_d1 <= 1'b0;
      end else begin
         hit_d1   <= hit_c;
         video_d1 <= bus.video_on;
      end
   end

   // Stage 1 data; only meaningful when the qualifiers are set.
   always_ff @(posedge clk) begin
      lx_d1    <= lx_c;
      ly_d1    <= ly_c;
      digit_d1 <= digit_c;
   end

   // ------------------------------------------------------------------
   // Stage 2: segment hit test and colour
   // ------------------------------------------------------------------
   logic [6:0] seg_hit;
   logic       lit;

   // Bar regions of the glyph, packed {a,b,c,d,e,f,g}.
   always_comb begin
      seg_hit[6] = ly_d1 < BAR_W;
      seg_hit[5] = lx_d1 >= RIGHT_BAR && ly_d1 < MID_HI;
      seg_hit[4] = lx_d1 >= RIGHT_BAR && ly_d1 >= MID_LO;
      seg_hit[3] = ly_d1 >= BOT_BAR;
      seg_hit[2] = lx_d1 < BAR_W && ly_d1 >= MID_LO;
      seg_hit[1] = lx_d1 < BAR_W && ly_d1 < MID_HI;
      seg_hit[0] = ly_d1 >= MID_LO && ly_d1 < MID_HI;
      lit        = |(seg_hit & seg_mask(digit_d1));
   end

   // Output colour register.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.rgb_out <= 12'h000;
      end else if (video_d1 && hit_d1 && lit) begin
         bus.rgb_out <= bus.fg_rgb;
      end else begin
         bus.rgb_out <= 12'h000;
      end
   end

endmodule

// File: tb/tb_digit_render_sched.sv
// Self-checking bench for digit_render_sched: a pixel-level model of the
// timer overlay runs alongside the DUT and every cycle's rgb_out and
// digits_ready are compared against it, plus hand-computed spot checks.
module tb_digit_render_sched;

   localparam int NUM_DIGITS = 4;
   localparam int DIG_W      = 80;
   localparam int DIG_H      = 160;
   localparam int BAR        = 10;
   localparam int GAP        = 16;
   localparam int ORIGIN_X   = 144;
   localparam int ORIGIN_Y   = 160;
   localparam logic [11:0] FG = 12'h5E3;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   digit_render_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

   digit_render_sched #(
      .NUM_DIGITS (NUM_DIGITS),
      .DIG_W      (DIG_W),
      .DIG_H      (DIG_H),
      .BAR        (BAR),
      .GAP        (GAP),
      .ORIGIN_X   (ORIGIN_X),
      .ORIGIN_Y   (ORIGIN_Y)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: segments named by letter, glyph tested per pixel.
   // ------------------------------------------------------------------
   string seg_tab [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                           "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

   function automatic bit seg_lit(input string s, input int lx, input int ly);
      bit on = 1'b0;
      for (int i = 0; i < s.len(); i++) begin
         case (s.getc(i))
            "a": on = on | (ly < BAR);
            "b": on = on | (lx >= DIG_W - BAR && ly < (DIG_H + BAR) / 2);
            "c": on = on | (lx >= DIG_W - BAR && ly >= (DIG_H - BAR) / 2);
            "d": on = on | (ly >= DIG_H - BAR);
            "e": on = on | (lx < BAR && ly >= (DIG_H - BAR) / 2);
            "f": on = on | (lx < BAR && ly < (DIG_H + BAR) / 2);
            "g": on = on | (ly >= (DIG_H - BAR) / 2 && ly < (DIG_H + BAR) / 2);
            default: ;
         endcase
      end
      return on;
   endfunction

   function automatic logic [11:0] model_pixel(input int x, input int y, input bit von,
                                               input logic [15:0] act, input logic [11:0] fg);
      logic [11:0] res = 12'h000;
      int left;
      int d;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         left = ORIGIN_X + k * (DIG_W + GAP);
         if (von && x >= left && x < left + DIG_W && y >= ORIGIN_Y && y < ORIGIN_Y + DIG_H) begin
            d = int'((act >> (4 * k)) & 16'hF);
            if (d <= 9 && seg_lit(seg_tab[d], x - left, y - ORIGIN_Y)) res = fg;
         end
      end
      return res;
   endfunction

   bit          model_live = 1'b0;
   bit          m_full     = 1'b0;
   logic [15:0] m_active   = 16'hFFFF;
   logic [15:0] m_shadow   = 16'h0000;
   logic [11:0] exp1       = 12'h000;
   logic [11:0] exp2       = 12'h000;

   // Model advances on each rising edge using the inputs held across it.
   always @(posedge clk) begin
      if (reset) begin
         model_live = 1'b1;
         m_full     = 1'b0;
         m_active   = 16'hFFFF;
         exp1       = 12'h000;
         exp2       = 12'h000;
      end else begin
         exp2 = exp1;
         exp1 = model_pixel(int'(bus.pixel_x), int'(bus.pixel_y), bus.video_on, m_active, bus.fg_rgb);
         if (!m_full && bus.digits_valid) begin
            if (bus.frame_start) begin
               m_active = bus.digits_in;
            end else begin
               m_shadow = bus.digits_in;
               m_full   = 1'b1;
            end
         end else if (m_full && bus.frame_start) begin
            m_active = m_shadow;
            m_full   = 1'b0;
         end
      end
   end

   // Compare process: outputs checked on every falling edge.
   always @(negedge clk) begin
      if (model_live) begin
         check("rgb_out stream", {4'h0, bus.rgb_out}, {4'h0, exp2});
         check("digits_ready stream", {15'h0, bus.digits_ready}, {15'h0, (!reset && !m_full)});
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_pixel(input int x, input int y, input bit v);
      bus.pixel_x  = 10'(x);
      bus.pixel_y  = 10'(y);
      bus.video_on = v;
   endtask

   task automatic probe(input string name, input int x, input int y, input bit v, input logic [11:0] exp);
      set_pixel(x, y, v);
      tick(2);
      check(name, {4'h0, bus.rgb_out}, {4'h0, exp});
   endtask

   task automatic scan(input int ystep);
      for (int y = 150; y < 330; y += ystep) begin
         for (int x = 130; x < 540; x++) begin
            set_pixel(x, y, 1'b1);
            tick(1);
         end
      end
   endtask

   task automatic load(input logic [15:0] d);
      bus.digits_in    = d;
      bus.digits_valid = 1'b1;
      tick(1);
      bus.digits_valid = 1'b0;
   endtask

   task automatic frame();
      bus.frame_start = 1'b1;
      tick(1);
      bus.frame_start = 1'b0;
   endtask

   initial begin
      bus.pixel_x      = '0;
      bus.pixel_y      = '0;
      bus.video_on     = 1'b0;
      bus.frame_start  = 1'b0;
      bus.digits_in    = '0;
      bus.digits_valid = 1'b0;
      bus.fg_rgb       = FG;
      reset            = 1'b1;
      tick(3);
      reset = 1'b0;
      #1;
      check("ready after reset", {15'h0, bus.digits_ready}, 16'h0001);
      check("rgb after reset", {4'h0, bus.rgb_out}, 16'h0000);

      // Blank frame.
      frame();
      scan(10);
      probe("blank slot0 a", 184, 165, 1'b1, 12'h000);

      // Load 1259 through the shadow.
      load(16'h1259);
      check("ready low while full", {15'h0, bus.digits_ready}, 16'h0000);
      frame();
      check("ready after publish", {15'h0, bus.digits_ready}, 16'h0001);
      probe("slot0 9 seg a", 184, 165, 1'b1, FG);
      probe("slot0 9 seg e", 149, 280, 1'b1, 12'h000);
      probe("slot3 1 seg b", 507, 165, 1'b1, FG);
      probe("slot3 1 seg a", 472, 165, 1'b1, 12'h000);
      scan(7);

      // Second load held off while the first is pending.
      load(16'h0000);
      bus.digits_in    = 16'h1111;
      bus.digits_valid = 1'b1;
      tick(3);
      check("second load held off", {15'h0, bus.digits_ready}, 16'h0000);
      bus.frame_start = 1'b1;
      tick(1);
      bus.frame_start  = 1'b0;
      bus.digits_valid = 1'b0;
      check("ready after held load", {15'h0, bus.digits_ready}, 16'h0001);
      probe("slot1 0 seg a", 280, 165, 1'b1, FG);
      probe("slot1 0 seg g", 280, 240, 1'b1, 12'h000);
      probe("slot3 0 centre", 472, 240, 1'b1, 12'h000);

      // Valid and frame_start together while empty: direct load.
      set_pixel(376, 165, 1'b1);
      bus.digits_in    = 16'h1A00;
      bus.digits_valid = 1'b1;
      bus.frame_start  = 1'b1;
      tick(1);
      bus.digits_valid = 1'b0;
      bus.frame_start  = 1'b0;
      check("ready after direct load", {15'h0, bus.digits_ready}, 16'h0001);
      tick(1);
      check("old digit in load cycle", {4'h0, bus.rgb_out}, {4'h0, FG});
      tick(1);
      check("new digit next cycle", {4'h0, bus.rgb_out}, 16'h0000);
      probe("first gap column", 224, 165, 1'b1, 12'h000);
      probe("slot1 lx0", 240, 165, 1'b1, FG);
      probe("slot2 digit A", 376, 165, 1'b1, 12'h000);
      probe("video off over lit", 184, 165, 1'b0, 12'h000);

      // Reset mid-frame drops the pending shadow.
      set_pixel(184, 165, 1'b1);
      tick(3);
      check("lit before reset", {4'h0, bus.rgb_out}, {4'h0, FG});
      load(16'h8888);
      reset = 1'b1;
      tick(1);
      check("rgb cleared by reset", {4'h0, bus.rgb_out}, 16'h0000);
      check("ready low in reset", {15'h0, bus.digits_ready}, 16'h0000);
      reset = 1'b0;
      frame();
      probe("pending dropped by reset", 184, 165, 1'b1, 12'h000);

      // Randomized traffic checked by the stream compare.
      for (int i = 0; i < 30000; i++) begin
         set_pixel(int'($urandom_range(560, 120)), int'($urandom_range(340, 140)),
                   $urandom_range(9, 0) != 0);
         bus.digits_in    = {4'($urandom_range(11, 0)), 4'($urandom_range(11, 0)),
                             4'($urandom_range(11, 0)), 4'($urandom_range(11, 0))};
         bus.digits_valid = ($urandom_range(3, 0) == 0);
         bus.frame_start  = ($urandom_range(40, 0) == 0);
         reset            = ($urandom_range(2000, 0) == 0);
         tick(1);
      end
      reset            = 1'b0;
      bus.digits_valid = 1'b0;
      bus.frame_start  = 1'b0;
      tick(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
